// File: rtl/reg_file_p_if.sv
// Operand-fetch / writeback bus of the register file: two read ports, one write port,
// per-port completion pulses and a busy indication while the contents are being cleared.
interface reg_file_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              re1;
  logic [ADDR_W-1:0] read_addr1;
  logic [DATA_W-1:0] read_data1;
  logic              re2;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] read_data2;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              read_finished;
  logic              write_finished;
  logic              busy;

  modport master (
    output re1, read_addr1, re2, read_addr2, we, write_addr, write_data,
    input  read_data1, read_data2, read_finished, write_finished, busy
  );

  modport slave (
    input  re1, read_addr1, re2, read_addr2, we, write_addr, write_data,
    output read_data1, read_data2, read_finished, write_finished, busy
  );
endinterface

// File: rtl/reg_file_p.sv
// CPU register file: two registered read ports with write-to-read bypass, one write port,
// optional hardwired-zero r0, and a self-clearing sweep after reset.
module reg_file_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  reg_file_p_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_idx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd2_q;
  logic              rf_q, wf_q, busy_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd1_next, rd2_next;

  // Bypass takes the value being written this cycle; r0 overrides everything when hardwired.
  function automatic logic [DATA_W-1:0] port_value(
    input logic [ADDR_W-1:0] addr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (ZERO_R0 && addr == '0)        return '0;
    if (wr_en && wr_addr == addr)     return wr_data;
    return stored;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.write_addr;
    mem_wdata = bus.write_data;
    if (!clr) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = sweep_idx;
        mem_wdata = '0;
      end else if (bus.we && !(ZERO_R0 && bus.write_addr == '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_comb begin
    rd1_next = port_value(bus.read_addr1, bus.we, bus.write_addr, bus.write_data,
                          regs[bus.read_addr1]);
    rd2_next = port_value(bus.read_addr2, bus.we, bus.write_addr, bus.write_data,
                          regs[bus.read_addr2]);
  end

  // NOTE: the array has no reset term; the sweep clears it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_addr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= CLEAR;
      sweep_idx <= '0;
      busy_q    <= 1'b1;
      rd1_q     <= '0;
      rd2_q     <= '0;
      rf_q      <= 1'b0;
      wf_q      <= 1'b0;
    end else begin
      rf_q <= 1'b0;
      wf_q <= 1'b0;
      case (state)
        CLEAR: begin
          sweep_idx <= sweep_idx + ADDR_W'(1);
          if (&sweep_idx) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          if (bus.re1) rd1_q <= rd1_next;
          if (bus.re2) rd2_q <= rd2_next;
          rf_q <= bus.re1 | bus.re2;
          wf_q <= bus.we;
        end
      endcase
    end
  end

  assign bus.read_data1     = rd1_q;
  assign bus.read_data2     = rd2_q;
  assign bus.read_finished  = rf_q;
  assign bus.write_finished = wf_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_reg_file_p.sv
// Bench for reg_file_p: default instance (32x32, hardwired r0) and a small instance
// (8x16, ordinary r0), both checked against array models under random and directed traffic.
module tb_reg_file_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_b;
  reg_file_p_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  reg_file_p_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

  reg_file_p #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1'b1)) dut_a (.clk(clk), .clr(clr_a), .bus(bus_a));
  reg_file_p #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b0)) dut_b (.clk(clk), .clr(clr_b), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_a [32];
  logic [31:0] exp_a1, exp_a2;
  logic [15:0] mem_b [8];
  logic [15:0] exp_b1, exp_b2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference semantics: r0 of instance A is always zero, otherwise the newest value wins.
  function automatic logic [31:0] ref_read_a(input logic [4:0] addr, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (addr == 5'd0) return 32'h0;
    if (we && wa == addr) return wd;
    return mem_a[addr];
  endfunction

  function automatic logic [15:0] ref_read_b(input logic [2:0] addr, input bit we,
                                             input logic [2:0] wa, input logic [15:0] wd);
    if (we && wa == addr) return wd;
    return mem_b[addr];
  endfunction

  task automatic step_a(input bit re1, input logic [4:0] a1, input bit re2, input logic [4:0] a2,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd, input string tag);
    bus_a.re1 = re1; bus_a.read_addr1 = a1;
    bus_a.re2 = re2; bus_a.read_addr2 = a2;
    bus_a.we  = we;  bus_a.write_addr = wa; bus_a.write_data = wd;
    if (re1) exp_a1 = ref_read_a(a1, we, wa, wd);
    if (re2) exp_a2 = ref_read_a(a2, we, wa, wd);
    @(posedge clk); #1;
    if (we && wa != 5'd0) mem_a[wa] = wd;
    check({tag, ".rd1"},  bus_a.read_data1, exp_a1);
    check({tag, ".rd2"},  bus_a.read_data2, exp_a2);
    check({tag, ".rfin"}, bus_a.read_finished, re1 | re2);
    check({tag, ".wfin"}, bus_a.write_finished, we);
    check({tag, ".busy"}, bus_a.busy, 1'b0);
  endtask

  task automatic step_b(input bit re1, input logic [2:0] a1, input bit re2, input logic [2:0] a2,
                        input bit we, input logic [2:0] wa, input logic [15:0] wd, input string tag);
    bus_b.re1 = re1; bus_b.read_addr1 = a1;
    bus_b.re2 = re2; bus_b.read_addr2 = a2;
    bus_b.we  = we;  bus_b.write_addr = wa; bus_b.write_data = wd;
    if (re1) exp_b1 = ref_read_b(a1, we, wa, wd);
    if (re2) exp_b2 = ref_read_b(a2, we, wa, wd);
    @(posedge clk); #1;
    if (we) mem_b[wa] = wd;
    check({tag, ".rd1"},  bus_b.read_data1, exp_b1);
    check({tag, ".rd2"},  bus_b.read_data2, exp_b2);
    check({tag, ".rfin"}, bus_b.read_finished, re1 | re2);
    check({tag, ".wfin"}, bus_b.write_finished, we);
    check({tag, ".busy"}, bus_b.busy, 1'b0);
  endtask

  task automatic idle_a();
    bus_a.re1 = 0; bus_a.re2 = 0; bus_a.we = 0;
    bus_a.read_addr1 = '0; bus_a.read_addr2 = '0; bus_a.write_addr = '0; bus_a.write_data = '0;
  endtask

  task automatic idle_b();
    bus_b.re1 = 0; bus_b.re2 = 0; bus_b.we = 0;
    bus_b.read_addr1 = '0; bus_b.read_addr2 = '0; bus_b.write_addr = '0; bus_b.write_data = '0;
  endtask

  // Counts edges with clr low until busy drops, while requests are held active on the bus.
  task automatic count_busy_a(output int n, output bit flagged);
    n = 0; flagged = 0;
    while (bus_a.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus_a.read_finished !== 1'b0 || bus_a.write_finished !== 1'b0) flagged = 1;
    end
  endtask

  task automatic count_busy_b(output int n, output bit flagged);
    n = 0; flagged = 0;
    while (bus_b.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus_b.read_finished !== 1'b0 || bus_b.write_finished !== 1'b0) flagged = 1;
    end
  endtask

  task automatic test_a();
    int  n;
    bit  fl;
    // Reset with requests asserted: clr must win and the requests must be dropped.
    clr_a = 1'b1;
    bus_a.re1 = 1; bus_a.read_addr1 = 5'd5; bus_a.re2 = 1; bus_a.read_addr2 = 5'd9;
    bus_a.we  = 1; bus_a.write_addr = 5'd5; bus_a.write_data = 32'hBAD0_0005;
    @(posedge clk); #1;
    check("a.rst.busy", bus_a.busy, 1'b1);
    check("a.rst.rd1",  bus_a.read_data1, 32'h0);
    check("a.rst.rd2",  bus_a.read_data2, 32'h0);
    check("a.rst.rfin", bus_a.read_finished, 1'b0);
    check("a.rst.wfin", bus_a.write_finished, 1'b0);
    clr_a = 1'b0;
    count_busy_a(n, fl);
    check("a.sweep_len", n, 32);
    check("a.sweep_flags", fl, 1'b0);
    idle_a();
    foreach (mem_a[i]) mem_a[i] = 32'h0;
    exp_a1 = 32'h0; exp_a2 = 32'h0;

    for (int i = 0; i < 32; i++) step_a(1, 5'(i), 1, 5'(31 - i), 0, 5'd0, 32'h0, "a.clear_rd");

    step_a(0, 5'd0, 0, 5'd0, 1, 5'd5, 32'hDEADBEEF, "a.wr5");
    step_a(1, 5'd5, 0, 5'd0, 0, 5'd0, 32'h0, "a.rd5");
    check("a.rd5_val", bus_a.read_data1, 32'hDEADBEEF);
    step_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0, "a.idle");

    step_a(0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h11, "a.wr7");
    step_a(1, 5'd7, 1, 5'd7, 1, 5'd7, 32'h22, "a.byp7");
    check("a.byp7_p1", bus_a.read_data1, 32'h22);
    check("a.byp7_p2", bus_a.read_data2, 32'h22);

    step_a(1, 5'd0, 1, 5'd0, 1, 5'd0, 32'h1234, "a.zero");
    check("a.zero_val", bus_a.read_data1, 32'h0);
    check("a.zero_wfin", bus_a.write_finished, 1'b1);
    step_a(1, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0, "a.zero_rd");

    step_a(0, 5'd0, 0, 5'd0, 1, 5'd3, 32'hA5, "a.wr3");
    step_a(1, 5'd3, 0, 5'd0, 0, 5'd0, 32'h0, "a.rd3");
    for (int i = 0; i < 3; i++) step_a(0, 5'd0, 0, 5'd0, 1, 5'd3, 32'h5A, "a.hold");
    check("a.hold_val", bus_a.read_data1, 32'hA5);
    check("a.hold_rfin", bus_a.read_finished, 1'b0);
    step_a(1, 5'd3, 0, 5'd0, 0, 5'd0, 32'h0, "a.rd3_new");
    check("a.rd3_new_val", bus_a.read_data1, 32'h5A);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] a1, a2, wa;
      bit narrow;
      narrow = $urandom_range(0, 1) == 1;
      a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      step_a(1'($urandom), a1, 1'($urandom), a2, 1'($urandom), wa, $urandom, "a.rand");
    end
    idle_a();
  endtask

  task automatic test_b();
    int n;
    bit fl;
    idle_b();
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    count_busy_b(n, fl);
    check("b.sweep_len", n, 8);
    foreach (mem_b[i]) mem_b[i] = 16'h0;
    exp_b1 = 16'h0; exp_b2 = 16'h0;

    for (int i = 0; i < 8; i++) step_b(0, 3'd0, 0, 3'd0, 1, 3'(i), 16'hC000 + 16'(i), "b.fill");
    idle_b();

    // Restart the sweep after indices 0..3 have been cleared.
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("b.mid_busy", bus_b.busy, 1'b1);
    clr_b = 1'b1;
    @(posedge clk); #1;
    check("b.mid_rst_busy", bus_b.busy, 1'b1);
    check("b.mid_rst_rd1", bus_b.read_data1, 16'h0);
    clr_b = 1'b0;
    count_busy_b(n, fl);
    check("b.restart_len", n, 8);
    check("b.restart_flags", fl, 1'b0);
    foreach (mem_b[i]) mem_b[i] = 16'h0;
    exp_b1 = 16'h0; exp_b2 = 16'h0;

    for (int i = 0; i < 8; i++) step_b(1, 3'(i), 1, 3'(7 - i), 0, 3'd0, 16'h0, "b.clear_rd");

    step_b(1, 3'd0, 1, 3'd0, 1, 3'd0, 16'h1234, "b.r0_byp");
    check("b.r0_byp_val", bus_b.read_data1, 16'h1234);
    check("b.r0_wfin", bus_b.write_finished, 1'b1);
    step_b(0, 3'd0, 0, 3'd0, 1, 3'd7, 16'hFFFF, "b.wr7");
    step_b(1, 3'd7, 0, 3'd0, 0, 3'd0, 16'h0, "b.rd7");
    check("b.rd7_val", bus_b.read_data1, 16'hFFFF);

    for (int i = 0; i < 200; i++)
      step_b(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
             1'($urandom), 3'($urandom), 16'($urandom), "b.rand");
    idle_b();
  endtask

  initial begin
    clr_a = 1'b1;
    clr_b = 1'b1;
    idle_a();
    idle_b();
    test_a();
    test_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_p.md
# reg_file_p

Parametrised general-purpose register file for the single-cycle/multi-cycle CPU datapath. It provides two registered read ports and one write port with per-port done flags, same-cycle write-to-read bypass and an optional hardwired-zero register 0. After reset it clears its own contents with an internal sweep state machine, so no memory-image file is required. It sits between instruction decode (operand fetch) and writeback.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- ZERO_R0, 1: 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary.

- clk  in  1  single clock; all state updates on posedge.
- clr  in  1  reset, synchronous, active-high.
- re1  in  1  read request, port 1.
- read_addr1  in  ADDR_W  read address, port 1.
- read_data1  out  DATA_W  registered read data, port 1.
- re2  in  1  read request, port 2.
- read_addr2  in  ADDR_W  read address, port 2.
- read_data2  out  DATA_W  registered read data, port 2.
- we  in  1  write request.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- read_finished  out  1  pulse: a read request was serviced in the previous cycle.
- write_finished  out  1  pulse: a write was committed in the previous cycle.
- busy  out  1  high while in reset or clear sweep; requests ignored.

## Operation
- States: CLEAR, READY. clr=1 at a posedge -> CLEAR, sweep index = 0.
- CLEAR: each cycle write 0 to regs[index], index++; after index DEPTH-1 is written -> READY. Sweep takes exactly DEPTH cycles after clr falls. busy=1 throughout CLEAR.
- clr asserted mid-sweep: sweep restarts from index 0.
- In CLEAR, re1/re2/we are ignored: no array write, read_data hold, both finished flags 0.
- READY, read: at posedge with re1=1, read_data1 <= value of regs[read_addr1] (same for port 2). re=0 -> that read_data holds its previous value.
- Bypass: if we=1 and write_addr equals a port's read address in the same cycle, that port returns write_data (new value), subject to the ZERO_R0 rule.
- ZERO_R0=1: address 0 reads 0 regardless of bypass; writes to address 0 do not change the array but still count as committed.
- Both ports may read the same address; each port is independent.
- read_finished <= 1 iff READY and (re1 or re2) at that edge, else 0.
- write_finished <= 1 iff READY and we at that edge, else 0.
- Reading an address never written since the sweep returns 0.

## Timing
- Reset values (cycle after clr=1 edge): read_data1 = read_data2 = 0, read_finished = 0, write_finished = 0, busy = 1.
- busy deasserts on the edge that writes regs[DEPTH-1]; the first request is accepted on the following edge. Default params: clr falls before edge E0 -> busy=0 after edge E31, requests sampled from E32.
- Read latency 1 cycle: request at edge N -> data and read_finished valid after edge N, observable during cycle N+1.
- Write latency 1 cycle: we at edge N -> array updated at N; a read at edge N+1 returns the new value; write_finished high during cycle N+1.
- Back-to-back requests every cycle allowed; finished flags stay high continuously.
- clr has priority over all requests in the same cycle.

## Test plan
- Reset sweep: pulse clr 1 cycle -> busy=1 for exactly 32 cycles; then read all addresses -> all read 0; re1=1/we=1 during busy -> no finished pulse, no write.
- Write then read: we, addr 5 <- 0xDEADBEEF; next cycle re1 addr 5 -> read_data1=0xDEADBEEF, write_finished then read_finished pulses 1 cycle each.
- Bypass: regs[7]=0x11; same cycle we addr 7 <- 0x22, re1 addr 7, re2 addr 7 -> both ports return 0x22.
- Zero register (ZERO_R0=1): write 0x1234 to addr 0, bypass read addr 0 -> 0; write_finished=1. With ZERO_R0=0, same sequence reads 0x1234.
- Hold behaviour: read addr 3 (=0xA5), then re1=0 for 3 cycles while writing addr 3 <- 0x5A -> read_data1 holds 0xA5, read_finished=0.
- Reset mid-sweep and params DATA_W=16, ADDR_W=3: assert clr at sweep index 4 -> sweep restarts, busy lasts 8 cycles after clr falls; write 0xFFFF to addr 7 reads back 0xFFFF.
